// File: rtl/imem_loader.sv
// Instruction-memory writer: turns a little-endian byte stream (16-bit word count,
// then 4*N bytes) into 32-bit word writes at BASE_ADDR, BASE_ADDR+4, ... while holding the core.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR     = 32'd0,
   parameter int          MAX_WORDS     = 16,
   parameter bit          HOLD_AT_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_BYTE,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] word_q, word_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        hold_q, hold_d;
   logic        xfer;
   logic [15:0] len_rx;

   // Readiness is a pure function of state so the source may hold in_valid freely.
   assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_BYTE);
   assign xfer     = in_valid && in_ready;
   assign len_rx   = {in_data, len_q[7:0]};

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      busy_d     = busy_q;
      done_d     = done_q;
      error_d    = error_q;
      hold_d     = hold_q;

      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN_LO;
               busy_d  = 1'b1;
               hold_d  = 1'b1;
               done_d  = 1'b0;
               error_d = 1'b0;
            end
         end

         S_LEN_LO: begin
            if (xfer && !abort) begin
               len_d[7:0] = in_data;
               state_d    = S_LEN_HI;
            end
         end

         S_LEN_HI: begin
            if (xfer && !abort) begin
               len_d[15:8] = in_data;
               if (len_rx == 16'd0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  hold_d  = 1'b0;
               end else if ({1'b0, len_rx} > MAX_N) begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
                  busy_d  = 1'b0;
                  hold_d  = 1'b1;
               end else begin
                  state_d    = S_BYTE;
                  byte_cnt_d = 2'd0;
                  word_cnt_d = 16'd0;
               end
            end
         end

         S_BYTE: begin
            if (xfer && !abort) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               unique case (byte_cnt_q)
                  2'd0: word_d[7:0]   = in_data;
                  2'd1: word_d[15:8]  = in_data;
                  2'd2: word_d[23:16] = in_data;
                  2'd3: begin
                     // Fourth byte goes straight into the write data register.
                     state_d = S_WRITE;
                     we_d    = 1'b1;
                     addr_d  = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
                     wdata_d = {in_data, word_q};
                  end
                  default: ;
               endcase
            end
         end

         S_WRITE: begin
            word_cnt_d = word_cnt_q + 16'd1;
            if (!abort) begin
               if (word_cnt_d == len_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  hold_d  = 1'b0;
               end else begin
                  state_d = S_BYTE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Abort drops the partial word; words already written stay in memory.
      if (abort && busy_q) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         hold_d  = 1'b1;
         done_d  = 1'b0;
         error_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         len_q      <= 16'd0;
         word_cnt_q <= 16'd0;
         byte_cnt_q <= 2'd0;
         word_q     <= 24'd0;
         we_q       <= 1'b0;
         addr_q     <= BASE_ADDR;
         wdata_q    <= 32'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         hold_q     <= HOLD_AT_RESET;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         hold_q     <= hold_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign cpu_hold   = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (BASE_ADDR 0 and 0x20) share stimulus;
// writes are logged per instance and compared against hand-computed words.
module tb_imem_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [7:0]  in_data;
   logic        in_valid;

   logic        in_ready, imem_we, cpu_hold, busy, done, error;
   logic [31:0] imem_addr, imem_wdata;
   logic        in_ready2, imem_we2, cpu_hold2, busy2, done2, error2;
   logic [31:0] imem_addr2, imem_wdata2;

   int n_chk  = 0;
   int n_fail = 0;
   int rdy_viol = 0;

   logic [31:0] wa[$], wd[$], wa2[$], wd2[$];
   logic [7:0]  frame[$];

   imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(16), .HOLD_AT_RESET(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
   );

   imem_loader #(.BASE_ADDR(32'h20), .MAX_WORDS(16), .HOLD_AT_RESET(1'b1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
      .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
      .cpu_hold(cpu_hold2), .busy(busy2), .done(done2), .error(error2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Write log, sampled mid-cycle.
   always @(negedge clk) begin
      if (imem_we) begin
         wa.push_back(imem_addr);
         wd.push_back(imem_wdata);
         if (in_ready) rdy_viol++;
      end
      if (imem_we2) begin
         wa2.push_back(imem_addr2);
         wd2.push_back(imem_wdata2);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic clear_log();
      wa.delete(); wd.delete(); wa2.delete(); wd2.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge following the transfer edge.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n;
      if (gap) begin
         in_valid = 1'b0;
         in_data  = 8'hXX;
         @(negedge clk);
      end
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input bit gap);
      foreach (frame[i]) send_byte(frame[i], gap);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_in_ready", in_ready, 0);
      chk("rst_we", imem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_addr2", imem_addr2, 32'h20);
      chk("rst_wdata", imem_wdata, 32'h0);
      chk("rst_hold", cpu_hold, 1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_hold", cpu_hold, 1);

      // Basic load, continuous valid
      clear_log();
      pulse_start();
      chk("start_busy", busy, 1);
      chk("start_ready", in_ready, 1);
      frame = {8'h02, 8'h00, 8'h33, 8'h80, 8'h20, 8'h00, 8'hB3, 8'h00, 8'h21, 8'h40};
      send_frame(1'b0);
      chk("basic_done_early", done, 0);
      @(negedge clk);
      chk("basic_done", done, 1);
      chk("basic_hold", cpu_hold, 0);
      chk("basic_busy", busy, 0);
      chk("basic_nwr", wa.size(), 2);
      chk("basic_a0", qget(wa, 0), 32'h0);
      chk("basic_d0", qget(wd, 0), 32'h00208033);
      chk("basic_a1", qget(wa, 1), 32'h4);
      chk("basic_d1", qget(wd, 1), 32'h402100B3);
      chk("basic_hold_wdata", imem_wdata, 32'h402100B3);

      // Abort outside a load is ignored
      pulse_abort();
      chk("abort_done_ignored", done, 1);

      // Same frame with gaps on in_valid
      clear_log();
      pulse_start();
      chk("gap_done_cleared", done, 0);
      send_frame(1'b1);
      repeat (2) @(negedge clk);
      chk("gap_nwr", wa.size(), 2);
      chk("gap_d0", qget(wd, 0), 32'h00208033);
      chk("gap_a1", qget(wa, 1), 32'h4);
      chk("gap_d1", qget(wd, 1), 32'h402100B3);
      chk("gap_ready_in_write", rdy_viol, 0);
      chk("gap_done", done, 1);

      // N = 16, largest accepted
      clear_log();
      pulse_start();
      frame = {8'h10, 8'h00};
      for (int i = 0; i < 64; i++) frame.push_back(8'(i));
      send_frame(1'b0);
      @(negedge clk);
      chk("n16_nwr", wa.size(), 16);
      chk("n16_last_addr", qget(wa, 15), 32'h3C);
      chk("n16_last_data", qget(wd, 15), 32'h3F3E3D3C);
      chk("n16_done", done, 1);

      // N = 17 rejected
      clear_log();
      pulse_start();
      frame = {8'h11, 8'h00};
      send_frame(1'b0);
      chk("n17_error", error, 1);
      chk("n17_done", done, 0);
      chk("n17_busy", busy, 0);
      chk("n17_hold", cpu_hold, 1);
      chk("n17_ready", in_ready, 0);
      repeat (3) @(negedge clk);
      chk("n17_nwr", wa.size(), 0);

      // N = 0 completes straight after LEN_HI
      pulse_start();
      chk("n0_error_cleared", error, 0);
      frame = {8'h00, 8'h00};
      send_frame(1'b0);
      chk("n0_done", done, 1);
      chk("n0_hold", cpu_hold, 0);
      chk("n0_nwr", wa.size(), 0);

      // Abort mid word 1 of N = 3
      clear_log();
      pulse_start();
      frame = {8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      send_frame(1'b0);
      pulse_start();
      chk("busy_start_ignored", busy, 1);
      pulse_abort();
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_error", error, 0);
      chk("abort_hold", cpu_hold, 1);
      chk("abort_ready", in_ready, 0);
      chk("abort_nwr", wa.size(), 1);
      chk("abort_d0", qget(wd, 0), 32'h44332211);
      clear_log();
      pulse_start();
      frame = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_frame(1'b0);
      @(negedge clk);
      chk("post_abort_nwr", wa.size(), 1);
      chk("post_abort_a0", qget(wa, 0), 32'h0);
      chk("post_abort_d0", qget(wd, 0), 32'hDDCCBBAA);
      chk("post_abort_done", done, 1);

      // Asynchronous reset during BYTE of word 2
      clear_log();
      pulse_start();
      frame = {8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A};
      send_frame(1'b0);
      chk("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_we", imem_we, 0);
      chk("arst_ready", in_ready, 0);
      chk("arst_addr", imem_addr, 32'h0);
      chk("arst_wdata", imem_wdata, 32'h0);
      chk("arst_hold", cpu_hold, 1);
      chk("arst_done", done, 0);
      repeat (2) @(negedge clk);
      chk("arst_nwr", wa.size(), 2);
      rst_n = 1'b1;
      @(negedge clk);

      // Load, then reload from DONE on the BASE_ADDR = 0x20 instance
      frame = {8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00};
      clear_log();
      pulse_start();
      send_frame(1'b0);
      @(negedge clk);
      chk("first_d0", qget(wd, 0), 32'h00500513);
      chk("first_done2", done2, 1);
      clear_log();
      pulse_start();
      chk("reload_done_cleared", done2, 0);
      send_frame(1'b0);
      @(negedge clk);
      chk("reload_nwr", wa2.size(), 1);
      chk("reload_a0", qget(wa2, 0), 32'h20);
      chk("reload_d0", qget(wd2, 0), 32'h00500513);
      chk("reload_done", done2, 1);
      chk("reload_hold", cpu_hold2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
